if_stage: RTL

- Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the ID-stage decoder.
- Owns the PC register and issues word addresses to the synchronous-output-free (combinational-read) instruction ROM.
- Applies next-PC redirects (beq/blez/bltzal taken, j/jal, jr/jalr) computed in ID, with one architectural delay slot.
- Drives the IF/ID pipeline register (instr_d, pc_d, pc8_d, valid_d) that feeds the decoder. Supports stall and flush, and keeps a fetch counter and sticky fetch-fault flag.

---
 rtl/mips_pkg.sv | 24 ++
 rtl/if_stage_pc_reg.sv | 34 +++
 rtl/if_stage.sv | 80 ++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline front end: reset/ROM defaults,
// PC increments, the filler instruction and the fetch-address legality check.
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_3000;
  localparam logic [31:0] IMEM_BASE_DEF = 32'h0000_3000;
  localparam int          IMEM_AW_DEF   = 10;
  localparam logic [31:0] NOP_WORD_DEF  = 32'h0000_0000;

  localparam logic [31:0] PC_INC   = 32'd4;
  localparam logic [31:0] LINK_INC = 32'd8;

  // 33-bit arithmetic so a ROM window ending exactly at 2^32 is still handled.
  function automatic logic pc_ok(input logic [31:0] pc,
                                 input logic [31:0] base,
                                 input int          aw);
    logic [32:0] offset;
    logic [32:0] limit;
    offset = {1'b0, pc} - {1'b0, base};
    limit  = 33'd4 << aw;
    return (pc[1:0] == 2'b00) && (pc >= base) && (offset < limit);
  endfunction

endpackage

// File: rtl/if_stage_pc_reg.sv
// Fetch PC register with its next-PC selection (hold on stall, else redirect
// target, else sequential increment).
module pc_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc
);

  logic [31:0] pc_next;

  // A redirect during a stall is dropped; ID presents it again once unstalled.
  always_comb begin
    pc_next = pc + PC_INC;
    if (stall)
      pc_next = pc;
    else if (redirect)
      pc_next = redirect_pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pc <= RESET_PC;
    else
      pc <= pc_next;
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: drives the instruction ROM address, loads the IF/ID
// register, counts valid fetches and flags illegal fetch addresses.
module if_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] IMEM_BASE = IMEM_BASE_DEF,
  parameter int          IMEM_AW   = IMEM_AW_DEF,
  parameter logic [31:0] NOP_WORD  = NOP_WORD_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  input  logic               stall,
  input  logic               flush,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  output logic [31:0]        pc_f,
  output logic [31:0]        instr_d,
  output logic [31:0]        pc_d,
  output logic [31:0]        pc8_d,
  output logic               valid_d,
  output logic [31:0]        fetch_cnt,
  output logic               fault
);

  logic fetch_bad;
  logic load_normal;

  pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .pc         (pc_f)
  );

  assign imem_addr   = IMEM_AW'((pc_f - IMEM_BASE) >> 2);
  assign fetch_bad   = !pc_ok(pc_f, IMEM_BASE, IMEM_AW);
  assign load_normal = !flush && !stall;

  // Flush wins over stall; pc8_d tracks pc_d even for flushed bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_d <= NOP_WORD;
      pc_d    <= RESET_PC;
      pc8_d   <= RESET_PC + LINK_INC;
      valid_d <= 1'b0;
    end else if (flush) begin
      instr_d <= NOP_WORD;
      pc_d    <= pc_f;
      pc8_d   <= pc_f + LINK_INC;
      valid_d <= 1'b0;
    end else if (!stall) begin
      instr_d <= fetch_bad ? NOP_WORD : imem_rdata;
      pc_d    <= pc_f;
      pc8_d   <= pc_f + LINK_INC;
      valid_d <= !fetch_bad;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      fetch_cnt <= 32'd0;
    else if (load_normal && !fetch_bad)
      fetch_cnt <= fetch_cnt + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      fault <= 1'b0;
    else if (load_normal && fetch_bad)
      fault <= 1'b1;
  end

endmodule
